// File: rtl/fir_pkg.sv
// Shared width/latency helpers for the parametrised FIR filter.
package fir_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    function automatic int latency(input int taps);
        return clog2(taps) + 2;
    endfunction

    // Unity gain in the coefficient fixed-point format (COEF_ONE).
    function automatic int coef_one(input int coef_frac);
        return 1 << coef_frac;
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree, latency clog2(N_IN), output width IN_W+clog2(N_IN).
// No backpressure: a valid bit travels alongside the data every cycle.
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int IN_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_ni,
    input  logic                             vld_i,
    input  logic signed [IN_W-1:0]           dat_i [N_IN],
    output logic                             vld_o,
    output logic signed [IN_W+clog2(N_IN)-1:0] dat_o
);

    localparam int LVL   = clog2(N_IN);
    localparam int NP    = 1 << LVL;
    localparam int OUT_W = IN_W + LVL;

    typedef logic signed [OUT_W-1:0] node_t;

    node_t          pad [NP];
    node_t          s_q [LVL][NP/2];
    logic [LVL-1:0] v_q;

    // Zero-padding to a power of two: an odd operand is added to zero,
    // which is a registered pass-through.
    always_comb begin
        for (int j = 0; j < NP; j++) pad[j] = '0;
        for (int j = 0; j < N_IN; j++) pad[j] = node_t'(dat_i[j]);
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int l = 0; l < LVL; l++) begin
                for (int j = 0; j < NP/2; j++) s_q[l][j] <= '0;
            end
        end else begin
            v_q <= (v_q << 1) | LVL'(vld_i);
            for (int j = 0; j < NP/2; j++) begin
                s_q[0][j] <= pad[2*j] + pad[2*j+1];
            end
            for (int l = 1; l < LVL; l++) begin
                for (int j = 0; j < (NP >> (l + 1)); j++) begin
                    s_q[l][j] <= s_q[l-1][2*j] + s_q[l-1][2*j+1];
                end
            end
        end
    end

    assign vld_o = v_q[LVL-1];
    assign dat_o = s_q[LVL-1][0];

endmodule

// File: rtl/fir_filter_param.sv
// Pipelined direct-form FIR with loadable coefficients, latency clog2(NUM_TAPS)+2, no backpressure.
// Define FIR_OUT_SAT_EN to saturate the rounded result to OUT_W instead of wrapping.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int NUM_TAPS  = 8,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int OUT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      incoming_signal_x,
    input  logic                          coef_we,
    input  logic [clog2(NUM_TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic                          out_valid,
    output logic signed [OUT_W-1:0]       output_signal_y
);

    localparam int AW     = clog2(NUM_TAPS);
    localparam int PROD_W = prod_w(DATA_W, COEF_W);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam coef_t COEF_ONE = coef_t'(coef_one(COEF_FRAC));
    localparam acc_t  RND      = acc_t'(1) << (COEF_FRAC - 1);

    sample_t                 x_q [NUM_TAPS];
    coef_t                   b_q [NUM_TAPS];
    prod_t                   p_q [NUM_TAPS];
    logic                    v1_q, v2_q;
    logic                    wr_vld_q;
    logic [AW-1:0]           wr_addr_q;
    coef_t                   wr_dat_q;
    logic                    tree_vld;
    acc_t                    acc;
    logic signed [OUT_W-1:0] y_d, y_q;
    logic                    out_vld_q;

    // Coefficient writes land one edge late so a sample accepted on the
    // write edge still multiplies by the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k] <= '0;
                b_q[k] <= (k == 0) ? COEF_ONE : '0;
                p_q[k] <= '0;
            end
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                x_q[0] <= incoming_signal_x;
                for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                p_q[k] <= prod_t'(x_q[k]) * prod_t'(b_q[k]);
            end
            wr_vld_q  <= coef_we && (int'(coef_addr) < NUM_TAPS);
            wr_addr_q <= coef_addr;
            wr_dat_q  <= coef_data;
            if (wr_vld_q) b_q[wr_addr_q] <= wr_dat_q;
        end
    end

    fir_adder_tree #(
        .N_IN (NUM_TAPS),
        .IN_W (PROD_W)
    ) u_tree (
        .clk    (clk),
        .rst_ni (reset),
        .vld_i  (v2_q),
        .dat_i  (p_q),
        .vld_o  (tree_vld),
        .dat_o  (acc)
    );

`ifdef FIR_OUT_SAT_EN
    localparam acc_t OUT_MAX = acc_t'({1'b0, {(OUT_W-1){1'b1}}});
    localparam acc_t OUT_MIN = ~OUT_MAX;
    acc_t shifted;

    always_comb begin
        shifted = (acc + RND) >>> COEF_FRAC;
        if (shifted > OUT_MAX)      y_d = OUT_W'(OUT_MAX);
        else if (shifted < OUT_MIN) y_d = OUT_W'(OUT_MIN);
        else                        y_d = OUT_W'(shifted);
    end
`else
    always_comb begin
        y_d = OUT_W'((acc + RND) >>> COEF_FRAC);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_vld_q <= 1'b0;
            y_q       <= '0;
        end else begin
            out_vld_q <= tree_vld;
            if (tree_vld) y_q <= y_d;
        end
    end

    assign out_valid       = out_vld_q;
    assign output_signal_y = y_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param: table vectors plus scoreboarded sequences.
module tb_fir_filter_param;

    localparam int NUM_TAPS  = 8;
    localparam int DATA_W    = 16;
    // COEF_W widened so the ramp coefficients up to 8.0 are representable.
    localparam int COEF_W    = 20;
    localparam int COEF_FRAC = 14;
    localparam int OUT_W     = 16;
    localparam int LAT       = 5;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] incoming_signal_x = '0;
    logic                     coef_we = 1'b0;
    logic [2:0]               coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  output_signal_y;

    fir_filter_param #(
        .NUM_TAPS  (NUM_TAPS),
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .OUT_W     (OUT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .incoming_signal_x (incoming_signal_x),
        .coef_we           (coef_we),
        .coef_addr         (coef_addr),
        .coef_data         (coef_data),
        .out_valid         (out_valid),
        .output_signal_y   (output_signal_y)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int due; } sb_t;
    typedef struct { int b0; int x; int y; } vec_t;

    sb_t  sb [$];
    vec_t tbl [7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_y = 0;
    int   hist [NUM_TAPS];
    int   coef [NUM_TAPS];

    function automatic int scale(input longint acc);
        longint r;
        logic signed [15:0] w;
        r = (acc + 64'sd8192) >>> COEF_FRAC;
`ifdef FIR_OUT_SAT_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        w = r[15:0];
`else
        w = r[15:0];
`endif
        return int'(w);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            n_out++;
            last_y = int'(output_signal_y);
            if (sb.size() == 0) begin
                check("spurious_out_valid", int'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                check("y_value", int'(output_signal_y), e.val);
                check("latency", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("missing_out_valid", int'(out_valid), 1);
        end
    endtask

    task automatic drive(input bit v, input int x, input bit we, input int a, input int d,
                         input bit use_exp, input int exp);
        longint acc;
        sb_t    e;
        reset             = 1'b1;
        in_valid          = v;
        incoming_signal_x = DATA_W'(x);
        coef_we           = we;
        coef_addr         = 3'(a);
        coef_data         = COEF_W'(d);
        if (v) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            acc = 0;
            for (int k = 0; k < NUM_TAPS; k++) acc += longint'(hist[k]) * longint'(coef[k]);
            e.val = use_exp ? exp : scale(acc);
            e.due = cyc + 1 + LAT;
            sb.push_back(e);
        end
        if (we && a < NUM_TAPS) coef[a] = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
        idle(3);
        check("drain_empty", sb.size(), 0);
    endtask

    // Write strobe held during reset must be ignored.
    task automatic do_reset(input int n, input bit we_during);
        reset     = 1'b0;
        in_valid  = 1'b0;
        coef_we   = we_during;
        coef_addr = '0;
        coef_data = '0;
        sb.delete();
        for (int k = 0; k < NUM_TAPS; k++) begin
            hist[k] = 0;
            coef[k] = (k == 0) ? 16384 : 0;
        end
        for (int i = 0; i < n; i++) tick();
        reset   = 1'b1;
        coef_we = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(output_signal_y), 0);
    endtask

    initial begin
        int cur_b0;
        int n0;

        tbl[0] = '{16384, 100, 100};
        tbl[1] = '{16384, -5, -5};
        tbl[2] = '{16384, 32767, 32767};
        tbl[3] = '{8192, 3, 2};
        tbl[4] = '{8192, -3, -1};
        tbl[5] = '{8192, 1, 1};
        tbl[6] = '{8192, -1, 0};

        do_reset(3, 1'b0);

        // Passthrough and rounding vectors.
        cur_b0 = 16384;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].b0 != cur_b0) begin
                drive(1'b0, 0, 1'b1, 0, tbl[i].b0, 1'b0, 0);
                cur_b0 = tbl[i].b0;
            end
            drive(1'b1, tbl[i].x, 1'b0, 0, 0, 1'b1, tbl[i].y);
        end
        drain();

        // Impulse response against a ramp of coefficients.
        do_reset(1, 1'b0);
        for (int k = 0; k < NUM_TAPS; k++) drive(1'b0, 0, 1'b1, k, (k + 1) * 16384, 1'b0, 0);
        idle(1);
        for (int j = 0; j < NUM_TAPS; j++) drive(1'b1, (j == 0) ? 1 : 0, 1'b0, 0, 0, 1'b1, j + 1);
        drain();

        // Same impulse with two idle cycles between samples.
        n0 = n_out;
        for (int j = 0; j < NUM_TAPS; j++) begin
            drive(1'b1, (j == 0) ? 1 : 0, 1'b0, 0, 0, 1'b1, j + 1);
            idle(2);
        end
        drain();
        check("gap_out_count", n_out - n0, NUM_TAPS);

        // Overflow: every tap at 1.0, full-scale constant input.
        do_reset(2, 1'b0);
        for (int k = 1; k < NUM_TAPS; k++) drive(1'b0, 0, 1'b1, k, 16384, 1'b0, 0);
        idle(1);
        for (int j = 0; j < NUM_TAPS; j++) drive(1'b1, 32767, 1'b0, 0, 0, 1'b0, 0);
        drain();
`ifdef FIR_OUT_SAT_EN
        check("overflow_final", last_y, 32767);
`else
        check("overflow_final", last_y, -8);
`endif

        // Coefficient write on the same edge as a sample.
        do_reset(1, 1'b0);
        drive(1'b1, 7, 1'b1, 0, 0, 1'b1, 7);
        drive(1'b1, 9, 1'b0, 0, 0, 1'b1, 0);
        drain();

        // Reset with three samples in flight; b0 is 0 beforehand.
        n0 = n_out;
        drive(1'b1, 11, 1'b0, 0, 0, 1'b0, 0);
        drive(1'b1, 12, 1'b0, 0, 0, 1'b0, 0);
        drive(1'b1, 13, 1'b0, 0, 0, 1'b0, 0);
        do_reset(1, 1'b1);
        drive(1'b1, 42, 1'b0, 0, 0, 1'b1, 42);
        drain();
        check("midreset_out_count", n_out - n0, 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
Parametrised, fully pipelined direct-form FIR filter. It is the successor to the fixed FIR_filter.
- Adds runtime-loadable coefficients, valid qualification on input and output, fixed-point rounding and a registered adder tree.
- Sits between the sample source (ADC/file-driven stimulus) and downstream DSP. Accepts at most one sample per clock, with no backpressure.

Parameters:
NUM_TAPS, 8, number of taps (>=2; need not be a power of 2)
DATA_W, 16, signed input sample width
COEF_W, 16, signed coefficient width
COEF_FRAC, 14, fractional bits of coefficients (1.0 = 2**COEF_FRAC)
OUT_W, 16, signed output width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
in_valid  in  1  incoming_signal_x holds a new sample this cycle
incoming_signal_x  in  DATA_W  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NUM_TAPS)  tap index to write (0 = newest sample's tap, b0)
coef_data  in  COEF_W  signed coefficient value
out_valid  out  1  output_signal_y holds a new filtered sample
output_signal_y  out  OUT_W  signed filtered sample

Behaviour:
- Reset (reset==0 at clk edge):
  - delay line, products, tree registers, out_valid and output_signal_y all cleared to 0.
  - Coefficients reset to b0 = 2**COEF_FRAC (1.0), all others 0, i.e. passthrough.
- Delay line: shifts only on edges where in_valid==1 (x[0] <= input, x[k] <= x[k-1]). Gaps in in_valid do not disturb history.
- Pipeline advances every cycle, with a valid bit carried alongside each stage.
  - Stage 1 (edge t, sample accepted): delay line update.
  - Stage 2 (t+1): NUM_TAPS registered products p[k] = x[k]*b[k], full width DATA_W+COEF_W.
  - Stages 3..: registered pairwise adder tree, clog2(NUM_TAPS) levels. Odd operand counts pass through registered.
  - Final: output register.
  - LATENCY = clog2(NUM_TAPS)+2 edges after the accepting edge (5 for defaults). out_valid is high for exactly one cycle per accepted sample.
- Accumulator width ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS). No internal overflow.
- Output scaling:
  - Add 2**(COEF_FRAC-1), arithmetic shift right by COEF_FRAC (round half toward +inf).
  - Then reduce to OUT_W by two's-complement truncation (wrap).
- output_signal_y holds its last value while out_valid==0.
- Coefficient write:
  - If coef_we==1 at an edge, b[coef_addr] <= coef_data.
  - The new value is used by the product stage from the next edge onward. Samples already past stage 2 are unaffected.
  - A write with coef_addr >= NUM_TAPS is ignored.
- Simultaneous write and sample: the sample accepted on the same edge as the write uses the old coefficient for its product.
- Reset asserted mid-stream: all in-flight results are discarded (no out_valid for them). Coefficients revert to passthrough. coef_we is ignored while reset==0.

Optional Feature:
FIR_OUT_SAT_EN
- Defined: the final OUT_W reduction saturates to [-2**(OUT_W-1), 2**(OUT_W-1)-1] after rounding.
- Undefined: plain truncation (wrap), as in Behaviour.
- Latency is identical in both builds.

Decomposition:
- Package fir_pkg:
  - ACC_W/PROD_W/LATENCY derivation functions and clog2 helper.
  - Typedefs for sample, coefficient, product and accumulator (parametrised via localparams in the module).
  - Reset coefficient constant COEF_ONE = 2**COEF_FRAC.
- Sub-module fir_adder_tree:
  - Parametrised (N_IN, IN_W).
  - Registered pairwise reduction with a valid pipeline.
  - Output width IN_W+clog2(N_IN), latency clog2(N_IN).

Test Plan:
- Passthrough after reset: samples 100, -5, 32767 with in_valid=1 -> output_signal_y 100, -5, 32767 with out_valid exactly 5 cycles after each input.
- Impulse response:
  - Stimulus: load b[k] = (k+1)*16384 for k=0..7, then impulse 1 followed by seven 0s.
  - Response: outputs 1,2,...,8 on consecutive out_valid cycles.
- Valid gaps: same impulse with in_valid toggling 1,0,0,1,... -> identical output sequence 1..8. out_valid count equals accepted-sample count; no outputs during gaps.
- Rounding: b0=8192 (0.5), others 0.
  - Input 3 -> 2.
  - Input -3 -> -1.
  - Input 1 -> 1.
  - Input -1 -> 0.
- Overflow: all b[k]=16384, constant input 32767 for 8 samples.
  - With FIR_OUT_SAT_EN, final output -> 32767.
  - Without it, final output -> -8 (262136 wrapped).
- Reset mid-stream and coef write timing:
  - Mid-stream reset: assert reset=0 for one cycle with 3 samples in flight -> no out_valid for them. The next sample 42 then appears as 42 (passthrough restored).
  - Coefficient write timing: write b0=0 on the same edge as sample 7 -> output 7. The following sample 9 -> output 0.
